seq_md_alu: RTL and testbench
=============================

SEQ_MD_ALU -- requirements
Module: seq_md_alu

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: operation request.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-006 SHALL have port A, input, N bits: operand A.
REQ-007 SHALL have port B, input, N bits: operand B.
REQ-008 SHALL have port sel, input, 4 bits: opcode.
REQ-009 SHALL have port out_valid, output, 1 bit: result available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port ALUOutput, output, N bits: registered result.
REQ-012 SHALL have port CarryOut, output, 1 bit: carry of ADD, or not-borrow of SUB; 0 for all other ops.
REQ-013 SHALL have port zeroFlag, output, 1 bit: high when ALUOutput == 0.
REQ-014 SHALL have port illegal, output, 1 bit: the accepted sel was unencoded.

Function
REQ-015 SHALL decode sel as follows:
- 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0011 XOR.
- 0100 SLL, 0101 SRL, 0111 SRA; shift amount is B[log2(N)-1:0].
- 1000 SLT (signed), 1001 SLTU; result is 1 or 0, zero-extended.
- 1010 MUL (low N bits), 1011 MULHU (high N bits, unsigned).
- 1100 DIVU, 1101 REMU.
REQ-016 SHALL treat sel 1110 and 1111 as illegal: result 0, illegal=1, latency 1.
REQ-017 SHALL accept a request only on a rising edge where in_valid && in_ready, and SHALL capture A, B and sel at that edge.
REQ-018 SHALL implement a state machine with states IDLE, MUL, DIV and DONE.
REQ-019 SHALL drive in_ready=1 only in IDLE.
REQ-020 SHALL take IDLE->DONE on acceptance of a single-cycle op (0000-1001, illegal), so out_valid rises one cycle after acceptance.
REQ-021 SHALL take IDLE->MUL on acceptance of 1010/1011: shift-add over 2N-bit product, one bit per cycle, exactly N iteration cycles, then MUL->DONE.
REQ-022 SHALL take IDLE->DIV on acceptance of 1100/1101: restoring divider, one quotient bit per cycle, exactly N iteration cycles, then DIV->DONE.
REQ-023 SHALL assert out_valid for MUL/DIV ops exactly N+1 cycles after the acceptance edge.
REQ-024 SHALL make DIVU by zero return all ones and REMU by zero return A, with the full N-cycle latency and no flag.
REQ-025 SHALL hold out_valid=1 in DONE, with ALUOutput, CarryOut, zeroFlag and illegal stable, until out_valid && out_ready.
REQ-026 SHALL take DONE->IDLE on that edge; in_ready returns to 1 on the next cycle, giving a maximum throughput of one op per 2 cycles.
REQ-027 SHALL ignore in_valid, A, B and sel outside IDLE; operand changes during MUL/DIV SHALL NOT affect the result.
REQ-028 SHALL wrap ADD/SUB/MUL-low modulo 2^N.
REQ-029 SHALL register zeroFlag together with ALUOutput in the same cycle.

Reset
REQ-030 SHALL, while rst_n=0, force state=IDLE, in_ready=1, out_valid=0, ALUOutput=0, CarryOut=0, zeroFlag=1, illegal=0, and clear the iteration counter and partial product/remainder.
REQ-031 SHALL abort any MUL/DIV in progress on reset assertion with no result delivered, and SHALL accept a new request on the first edge after rst_n rises.

Verification
REQ-032 SHALL pass this scenario: ADD A=0xFFFFFFFF, B=1, out_ready=1 -> one cycle later out_valid=1, ALUOutput=0, CarryOut=1, zeroFlag=1.
REQ-033 SHALL pass this scenario: MUL and MULHU with A=B=0x00010000 -> MUL=0x00000000, zeroFlag=1; MULHU=0x00000001; out_valid exactly 33 cycles after acceptance.
REQ-034 SHALL pass this scenario: DIVU then REMU with A=7, B=0 -> 0xFFFFFFFF and 0x00000007; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-035 SHALL pass this scenario: SUB 5-3 with out_ready=0 for 5 cycles while A and B toggle -> ALUOutput=2 held, CarryOut=1, in_ready=0 throughout; one cycle after out_ready rises, in_ready=1.
REQ-036 SHALL pass this scenario: DIVU started, rst_n pulsed low at iteration cycle 10 -> out_valid never rises for it; after release, ADD 1+1 returns 2 with latency 1.
REQ-037 SHALL pass this scenario: sel=1111 -> illegal=1, ALUOutput=0; SRA 0x80000000 by 31 -> 0xFFFFFFFF; SLT A=-1, B=0 -> 1; SLTU A=-1, B=0 -> 0.

Source files
------------

// File: rtl/seq_md_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus an iterative shift-add
// multiplier and restoring divider, with valid/ready handshakes on both sides.
module seq_md_alu #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] ALUOutput,
  output logic         CarryOut,
  output logic         zeroFlag,
  output logic         illegal
);
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [SW-1:0]  cnt;
  logic [2*N-1:0] acc;      // {partial product | multiplier} or {remainder | dividend}
  logic [N-1:0]   opnd;     // multiplicand or divisor, frozen at acceptance
  logic           hi_sel;   // MULHU/REMU take the upper half of acc
  logic           is_mul;
  logic           is_div;
  logic           last_iter;

  logic [N-1:0]   alu_res;
  logic           alu_carry;
  logic           alu_illegal;
  logic [N:0]     add_sum;
  logic [N:0]     sub_sum;
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;
  logic [N:0]     rem_shift;
  logic [N:0]     div_diff;
  logic [2*N-1:0] div_next;
  logic [N-1:0]   mul_res;
  logic [N-1:0]   div_res;

  assign is_mul    = (sel[3:1] == 3'b101);
  assign is_div    = (sel[3:1] == 3'b110);
  assign last_iter = (cnt == LAST);

  // Single-cycle result from the live operands, used only at acceptance
  always_comb begin
    add_sum     = {1'b0, A} + {1'b0, B};
    sub_sum     = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, 1'b1};
    alu_res     = {N{1'b0}};
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    case (sel)
      OP_ADD:  begin alu_res = add_sum[N-1:0]; alu_carry = add_sum[N]; end
      OP_SUB:  begin alu_res = sub_sum[N-1:0]; alu_carry = sub_sum[N]; end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLL:  alu_res = A << B[SW-1:0];
      OP_SRL:  alu_res = A >> B[SW-1:0];
      OP_SRA:  alu_res = $signed(A) >>> B[SW-1:0];
      OP_SLT:  alu_res = {{(N-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(N-1){1'b0}}, (A < B)};
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: alu_res = {N{1'b0}};
      default: alu_illegal = 1'b1;
    endcase
  end

  // One shift-add step and one restoring-divide step on the shared accumulator
  always_comb begin
    mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : {(N+1){1'b0}});
    mul_next  = {mul_sum, acc[N-1:1]};
    rem_shift = acc[2*N-1:N-1];
    div_diff  = rem_shift - {1'b0, opnd};
    if (div_diff[N]) begin
      div_next = {rem_shift[N-1:0], acc[N-2:0], 1'b0};
    end else begin
      div_next = {div_diff[N-1:0], acc[N-2:0], 1'b1};
    end
    mul_res = hi_sel ? mul_next[2*N-1:N] : mul_next[N-1:0];
    div_res = hi_sel ? div_next[2*N-1:N] : div_next[N-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (is_mul) begin
            state_next = MUL;
          end else if (is_div) begin
            state_next = DIV;
          end else begin
            state_next = DONE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      MUL:     state_next = last_iter ? DONE : MUL;
      DIV:     state_next = last_iter ? DONE : DIV;
      DONE:    state_next = out_ready ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= {SW{1'b0}};
      acc       <= {(2*N){1'b0}};
      opnd      <= {N{1'b0}};
      hi_sel    <= 1'b0;
      ALUOutput <= {N{1'b0}};
      CarryOut  <= 1'b0;
      zeroFlag  <= 1'b1;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt    <= {SW{1'b0}};
            hi_sel <= sel[0];
            if (is_mul) begin
              acc  <= {{N{1'b0}}, B};
              opnd <= A;
            end else if (is_div) begin
              acc  <= {{N{1'b0}}, A};
              opnd <= B;
            end else begin
              ALUOutput <= alu_res;
              CarryOut  <= alu_carry;
              zeroFlag  <= (alu_res == {N{1'b0}});
              illegal   <= alu_illegal;
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + SW'(1);
          if (last_iter) begin
            ALUOutput <= mul_res;
            CarryOut  <= 1'b0;
            zeroFlag  <= (mul_res == {N{1'b0}});
            illegal   <= 1'b0;
          end
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + SW'(1);
          if (last_iter) begin
            ALUOutput <= div_res;
            CarryOut  <= 1'b0;
            zeroFlag  <= (div_res == {N{1'b0}});
            illegal   <= 1'b0;
          end
        end
        DONE: begin
          cnt <= {SW{1'b0}};
        end
        default: begin
          cnt <= {SW{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_md_alu.sv
// Randomized and directed bench for seq_md_alu (N=32) against an arithmetic
// reference model; operands are scrambled while the block is busy.
module tb_seq_md_alu;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUOutput;
  logic        CarryOut;
  logic        zeroFlag;
  logic        illegal;

  int checks;
  int failures;

  seq_md_alu #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUOutput (ALUOutput),
    .CarryOut  (CarryOut),
    .zeroFlag  (zeroFlag),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: plain 64-bit arithmetic on the opcode table
  function automatic void ref_model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic c, output logic ill,
                                    output int lat);
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned p;
    ua = 64'(a);
    ub = 64'(b);
    r = 32'd0; c = 1'b0; ill = 1'b0; lat = 1;
    case (s)
      4'b0010: begin p = ua + ub; r = p[31:0]; c = p[32]; end
      4'b0110: begin r = a - b; c = (a >= b); end
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b0100: r = a << b[4:0];
      4'b0101: r = a >> b[4:0];
      4'b0111: r = $signed(a) >>> b[4:0];
      4'b1000: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1001: r = (a < b) ? 32'd1 : 32'd0;
      4'b1010: begin p = ua * ub; r = p[31:0];  lat = 33; end
      4'b1011: begin p = ua * ub; r = p[63:32]; lat = 33; end
      4'b1100: begin r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b; lat = 33; end
      4'b1101: begin r = (b == 32'd0) ? a : a % b; lat = 33; end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 15));
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from a negedge, scramble inputs while busy, check result and handshake
  task automatic run_op(input string tag, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        ec;
    logic        ei;
    int          el;
    int          lat;
    int          t;
    ref_model(s, a, b, er, ec, ei, el);
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_val({tag, ".ready_in"}, 64'(in_ready), 64'd1);
    out_ready = (hold == 0);
    in_valid = 1'b1; A = a; B = b; sel = s;
    @(posedge clk);
    #1;
    A = $urandom; B = $urandom; sel = 4'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      A = $urandom; B = $urandom; sel = 4'($urandom);
    end while (!out_valid && lat < 100);
    in_valid = 1'b0;
    check_val({tag, ".latency"}, 64'(lat), 64'(el));
    check_val({tag, ".result"}, 64'(ALUOutput), 64'(er));
    check_val({tag, ".carry"}, 64'(CarryOut), 64'(ec));
    check_val({tag, ".zero"}, 64'(zeroFlag), 64'(er == 32'd0));
    check_val({tag, ".illegal"}, 64'(illegal), 64'(ei));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_val({tag, ".hold_result"}, 64'(ALUOutput), 64'(er));
      check_val({tag, ".hold_carry"}, 64'(CarryOut), 64'(ec));
      check_val({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      check_val({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
      A = $urandom; B = $urandom;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_val({tag, ".ready_back"}, 64'(in_ready), 64'd1);
    check_val({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = 32'd0; B = 32'd0; sel = 4'd0;
    repeat (3) @(negedge clk);
    check_val("rst.in_ready", 64'(in_ready), 64'd1);
    check_val("rst.out_valid", 64'(out_valid), 64'd0);
    check_val("rst.result", 64'(ALUOutput), 64'd0);
    check_val("rst.carry", 64'(CarryOut), 64'd0);
    check_val("rst.zero", 64'(zeroFlag), 64'd1);
    check_val("rst.illegal", 64'(illegal), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("mul_lo",   4'b1010, 32'h0001_0000, 32'h0001_0000, 0);
    run_op("mul_hi",   4'b1011, 32'h0001_0000, 32'h0001_0000, 0);
    run_op("divu_z",   4'b1100, 32'd7, 32'd0, 0);
    run_op("remu_z",   4'b1101, 32'd7, 32'd0, 0);
    run_op("divu",     4'b1100, 32'd100, 32'd7, 0);
    run_op("remu",     4'b1101, 32'd100, 32'd7, 0);
    run_op("sub_hold", 4'b0110, 32'd5, 32'd3, 5);
    run_op("illegal",  4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op("sra",      4'b0111, 32'h8000_0000, 32'd31, 0);
    run_op("slt",      4'b1000, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("sltu",     4'b1001, 32'hFFFF_FFFF, 32'd0, 0);

    // Reset in the middle of a divide: the divide must never complete
    out_ready = 1'b1;
    in_valid = 1'b1; A = 32'd100; B = 32'd7; sel = 4'b1100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_val("abort.busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check_val("abort.valid", 64'(out_valid), 64'd0);
    check_val("abort.ready", 64'(in_ready), 64'd1);
    check_val("abort.zero", 64'(zeroFlag), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add_after_rst", 4'b0010, 32'd1, 32'd1, 0);

    for (int i = 0; i < 60; i++) begin
      run_op("rnd", 4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
             int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
